pcpi_lockstep_checker: RTL
==========================

PCPI_LOCKSTEP_CHECKER -- requirements
Module: pcpi_lockstep_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width, legal 32 or 64.
REQ-002 SHALL have parameter STRICT, default 1: 1 = readies must coincide in cycle; 0 = latency-tolerant.
REQ-003 SHALL have parameter TIMEOUT, default 64: cycles allowed in ISSUE before abort, legal >= 2.
REQ-004 SHALL have parameter CNT_W, default 16, counter width.
REQ-005 SHALL have ports: clk in 1 clock; resetn in 1 reset, synchronous, active-low.
REQ-006 SHALL have ports: req_valid in 1; req_ready out 1; req_insn in 32; req_rs1/req_rs2/req_rs3 in XLEN each. Together these form the stimulus request.
REQ-007 SHALL have ports: pcpi_valid out 1; pcpi_insn out 32; pcpi_rs1/pcpi_rs2/pcpi_rs3 out XLEN each. These are broadcast to both DUTs.
REQ-008 SHALL have ports: ref_wr in 1, ref_rd in XLEN, ref_wait in 1, ref_ready in 1. mut_wr, mut_rd, mut_wait, mut_ready follow the same pattern.
REQ-009 SHALL have ports: done_valid out 1; done_match out 1; err_sticky out 1; err_code out 3; first_err_idx out CNT_W; txn_count out CNT_W; mismatch_count out CNT_W.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, REPORT.
- IDLE->ISSUE on req_valid&&req_ready.
- ISSUE->REPORT when both sides are acked, on timeout, or on STRICT skew.
- REPORT->IDLE unconditionally after 1 cycle.
REQ-011 SHALL assert req_ready only in IDLE, and register insn/rs1-3 on accept.
REQ-012 SHALL assert pcpi_valid exactly while in ISSUE; pcpi_* operands SHALL hold their registered values throughout.
REQ-013 SHALL set a per-side ack flag on the first ready pulse of that side in ISSUE, capturing wr and rd in the same cycle.
REQ-014 SHALL report a second ready from an already-acked side as err_code 5 (duplicate ready).
REQ-015 SHALL, with STRICT=1, report one side's ready without the other in the same cycle as err_code 1 (skew), and go to REPORT next cycle.
REQ-016 SHALL, with STRICT=1, report ref_wait!=mut_wait in any ISSUE cycle as err_code 1.
REQ-017 SHALL, on timeout (TIMEOUT cycles in ISSUE):
- neither side acked: match, code 0 (both rejected insn);
- exactly one side acked: err_code 4.
REQ-018 SHALL compare captured results as follows:
- wr differs: code 2;
- both wr=1 and rd differs: code 3;
- both wr=0: rd ignored.
REQ-019 SHALL prioritise simultaneous errors 4 > 5 > 1 > 2 > 3.
REQ-020 SHALL pulse done_valid for one cycle in REPORT, with done_match = (code==0) and err_code valid only while done_valid.
REQ-021 SHALL give the following latency:
- req accepted at cycle T: pcpi_valid=1 from T+1;
- last ready at cycle R: pcpi_valid=0 and done_valid=1 at R+1, req_ready=1 at R+2.
REQ-022 SHALL increment txn_count in REPORT and mismatch_count on !done_match; both SHALL saturate at all-ones.
REQ-023 SHALL set err_sticky on the first mismatch and capture first_err_idx = txn_count pre-increment; both SHALL hold until reset.

Reset
REQ-024 SHALL, while resetn=0 at a clk edge, return to IDLE from any state, including mid-ISSUE with no report.
REQ-025 SHALL have the following reset values:
- zero: pcpi_valid, done_valid, done_match, err_sticky, err_code, first_err_idx, txn_count, mismatch_count, ack flags, timeout counter;
- req_ready = 1 in the cycle after reset deasserts.

Structure
REQ-026 SHALL place the state enum, err_code enum (NONE=0, SKEW=1, WR=2, RD=3, TIMEOUT=4, DUP=5) and the XLEN legality check in package pcpi_chk_pkg.
REQ-027 SHALL use sub-module pcpi_chk_side (ack flag, wr/rd capture, duplicate detect), instantiated twice (ref, mut).

Verification
REQ-028 SHALL cover: STRICT=1, insn 0x0000_1033, both ready at cycle 3 with wr=1 and rd=0x1234 -> done_match=1, txn_count=1, req_ready high 2 cycles later.
REQ-029 SHALL cover: STRICT=0, ref ready at cycle 2, mut ready at cycle 9, equal rd -> done_match=1; same timing with STRICT=1 -> err_code 1 at cycle 3.
REQ-030 SHALL cover: both ready, wr=1, ref_rd=0xFFFF_FFFF vs mut_rd=0xFFFF_FFFE -> err_code 3, err_sticky=1, first_err_idx=0, mismatch_count=1.
REQ-031 SHALL cover: TIMEOUT=8 with neither ready -> done_match=1 after 8 ISSUE cycles; TIMEOUT=8 with only ref ready -> err_code 4.
REQ-032 SHALL cover: resetn=0 for 1 cycle mid-ISSUE -> pcpi_valid=0 next cycle, no done_valid, counters=0.
REQ-033 SHALL cover: XLEN=64, CNT_W=2, 5 matching transactions -> txn_count saturates at 3; then a duplicate ref ready -> err_code 5.

Source files
------------

// File: rtl/pcpi_chk_pkg.sv
// Shared types for the PCPI lockstep checker: FSM state, error codes and
// parameter legality helpers.
package pcpi_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SKEW    = 3'd1,
        ERR_WR      = 3'd2,
        ERR_RD      = 3'd3,
        ERR_TIMEOUT = 3'd4,
        ERR_DUP     = 3'd5
    } err_code_e;

    // Operand width must be RV32 or RV64.
    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/pcpi_lockstep_checker_side.sv
// One side (ref or mut) of the lockstep checker: records the first ready
// pulse of a transaction, captures wr/rd with it, and flags repeat readies.
//   clk, resetn    : clock, synchronous active-low reset
//   active         : checker is in ISSUE; ack is cleared whenever low
//   ready, wr, rd  : PCPI response of this side
//   acked_c        : side has acked (registered flag or first ready now)
//   dup_c          : ready seen again after the side already acked
//   wr_c, rd_c     : effective captured response (bypassed on first ready)
module pcpi_chk_side
    import pcpi_chk_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            active,
    input  logic            ready,
    input  logic            wr,
    input  logic [XLEN-1:0] rd,
    output logic            acked_c,
    output logic            dup_c,
    output logic            wr_c,
    output logic [XLEN-1:0] rd_c
);

    logic            ack_q, ack_d;
    logic            wr_q, wr_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            first_c;

    // Capture on the first ready of the transaction only.
    always_comb begin
        first_c = active && ready && !ack_q;
        dup_c   = active && ready && ack_q;
        ack_d   = active && (ack_q || first_c);
        wr_d    = first_c ? wr : wr_q;
        rd_d    = first_c ? rd : rd_q;
        acked_c = ack_q || first_c;
        wr_c    = wr_d;
        rd_c    = rd_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ack_q <= 1'b0;
            wr_q  <= 1'b0;
            rd_q  <= '0;
        end else begin
            ack_q <= ack_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/pcpi_lockstep_checker.sv
// Lockstep checker: broadcasts one PCPI request to a reference and a
// model-under-test coprocessor, compares their responses and reports.
//   clk, resetn              : clock, synchronous active-low reset
//   req_*                    : stimulus request (valid/ready handshake)
//   pcpi_*                   : request broadcast to both coprocessors
//   ref_*, mut_*             : responses of reference and model-under-test
//   done_valid/match/err_code: one-cycle per-transaction report
//   err_sticky, first_err_idx: first mismatch record, held until reset
//   txn_count, mismatch_count: saturating statistics
module pcpi_lockstep_checker
    import pcpi_chk_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter bit          STRICT  = 1'b1,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_insn,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [XLEN-1:0]  req_rs3,
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_insn,
    output logic [XLEN-1:0]  pcpi_rs1,
    output logic [XLEN-1:0]  pcpi_rs2,
    output logic [XLEN-1:0]  pcpi_rs3,
    input  logic             ref_wr,
    input  logic [XLEN-1:0]  ref_rd,
    input  logic             ref_wait,
    input  logic             ref_ready,
    input  logic             mut_wr,
    input  logic [XLEN-1:0]  mut_rd,
    input  logic             mut_wait,
    input  logic             mut_ready,
    output logic             done_valid,
    output logic             done_match,
    output logic             err_sticky,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] mismatch_count
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("pcpi_lockstep_checker: XLEN must be 32 or 64");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("pcpi_lockstep_checker: TIMEOUT must be >= 2");
    end

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       insn_q, insn_d;
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
    logic              req_ready_q, req_ready_d;
    logic              pcpi_valid_q, pcpi_valid_d;
    logic              done_valid_q, done_valid_d;
    logic              done_match_q, done_match_d;
    err_code_e         err_code_q, err_code_d;
    logic              err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
    logic [CNT_W-1:0]  txn_count_q, txn_count_d;
    logic [CNT_W-1:0]  mismatch_q, mismatch_d;

    logic              issue_c;
    logic              ref_acked_c, ref_dup_c, ref_wr_c;
    logic              mut_acked_c, mut_dup_c, mut_wr_c;
    logic [XLEN-1:0]   ref_rd_c, mut_rd_c;
    logic              both_c, tmo_hit_c, skew_c, dup_c, end_c;
    err_code_e         code_c;

    assign issue_c = (state_q == ST_ISSUE);

    pcpi_chk_side #(.XLEN(XLEN)) u_ref (
        .clk(clk), .resetn(resetn), .active(issue_c),
        .ready(ref_ready), .wr(ref_wr), .rd(ref_rd),
        .acked_c(ref_acked_c), .dup_c(ref_dup_c), .wr_c(ref_wr_c), .rd_c(ref_rd_c)
    );

    pcpi_chk_side #(.XLEN(XLEN)) u_mut (
        .clk(clk), .resetn(resetn), .active(issue_c),
        .ready(mut_ready), .wr(mut_wr), .rd(mut_rd),
        .acked_c(mut_acked_c), .dup_c(mut_dup_c), .wr_c(mut_wr_c), .rd_c(mut_rd_c)
    );

    // Per-cycle ISSUE evaluation; the code chain encodes 4 > 5 > 1 > 2 > 3.
    always_comb begin
        both_c    = ref_acked_c && mut_acked_c;
        tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT - 1));
        skew_c    = STRICT && ((ref_ready != mut_ready) || (ref_wait != mut_wait));
        dup_c     = ref_dup_c || mut_dup_c;
        end_c     = both_c || tmo_hit_c || skew_c || dup_c;
        code_c    = ERR_NONE;
        if (tmo_hit_c && !both_c && (ref_acked_c != mut_acked_c)) begin
            code_c = ERR_TIMEOUT;
        end else if (dup_c) begin
            code_c = ERR_DUP;
        end else if (skew_c) begin
            code_c = ERR_SKEW;
        end else if (both_c && (ref_wr_c != mut_wr_c)) begin
            code_c = ERR_WR;
        end else if (both_c && ref_wr_c && (ref_rd_c != mut_rd_c)) begin
            code_c = ERR_RD;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d         = state_q;
        tmo_d           = tmo_q;
        insn_d          = insn_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        rs3_d           = rs3_q;
        done_valid_d    = 1'b0;
        done_match_d    = 1'b0;
        err_code_d      = ERR_NONE;
        err_sticky_d    = err_sticky_q;
        first_err_idx_d = first_err_idx_q;
        txn_count_d     = txn_count_q;
        mismatch_d      = mismatch_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = ST_ISSUE;
                    tmo_d   = '0;
                    insn_d  = req_insn;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    rs3_d   = req_rs3;
                end
            end
            ST_ISSUE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (end_c) begin
                    state_d      = ST_REPORT;
                    done_valid_d = 1'b1;
                    done_match_d = (code_c == ERR_NONE);
                    err_code_d   = code_c;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
                if (txn_count_q != '1) begin
                    txn_count_d = txn_count_q + CNT_W'(1);
                end
                if (!done_match_q) begin
                    if (mismatch_q != '1) begin
                        mismatch_d = mismatch_q + CNT_W'(1);
                    end
                    if (!err_sticky_q) begin
                        err_sticky_d    = 1'b1;
                        first_err_idx_d = txn_count_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        pcpi_valid_d = (state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            tmo_q           <= '0;
            insn_q          <= '0;
            rs1_q           <= '0;
            rs2_q           <= '0;
            rs3_q           <= '0;
            req_ready_q     <= 1'b1;
            pcpi_valid_q    <= 1'b0;
            done_valid_q    <= 1'b0;
            done_match_q    <= 1'b0;
            err_code_q      <= ERR_NONE;
            err_sticky_q    <= 1'b0;
            first_err_idx_q <= '0;
            txn_count_q     <= '0;
            mismatch_q      <= '0;
        end else begin
            state_q         <= state_d;
            tmo_q           <= tmo_d;
            insn_q          <= insn_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            rs3_q           <= rs3_d;
            req_ready_q     <= req_ready_d;
            pcpi_valid_q    <= pcpi_valid_d;
            done_valid_q    <= done_valid_d;
            done_match_q    <= done_match_d;
            err_code_q      <= err_code_d;
            err_sticky_q    <= err_sticky_d;
            first_err_idx_q <= first_err_idx_d;
            txn_count_q     <= txn_count_d;
            mismatch_q      <= mismatch_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign pcpi_valid     = pcpi_valid_q;
    assign pcpi_insn      = insn_q;
    assign pcpi_rs1       = rs1_q;
    assign pcpi_rs2       = rs2_q;
    assign pcpi_rs3       = rs3_q;
    assign done_valid     = done_valid_q;
    assign done_match     = done_match_q;
    assign err_code       = err_code_q;
    assign err_sticky     = err_sticky_q;
    assign first_err_idx  = first_err_idx_q;
    assign txn_count      = txn_count_q;
    assign mismatch_count = mismatch_q;

endmodule
